// File: rtl/btn_pkg.sv
// Purpose: shared types and constant helpers for the set-button conditioner.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    PRESSED    = 3'd2,
    REPEAT     = 3'd3,
    DB_RELEASE = 3'd4
  } btn_state_t;

  // Milliseconds to clock cycles. Divide first so large clocks stay within int.
  function automatic int ms_to_cyc(int clk_hz, int ms);
    return clk_hz / 1000 * ms;
  endfunction

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clk cycles from d to q.
// Backpressure: none.
// Ports: clk (clock), rst (sync active-high, clears both flops), d (async in), q (synchronized out).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_set_cond.sv
// Purpose: debounce a set pushbutton, emit a press pulse plus auto-repeat while held.
// Latency: press/level rise 2+DB_CYC edges after btn_in is first sampled high; release symmetric.
// Backpressure: none; press is a single-cycle fire-and-forget pulse.
// Ports: clk, rst (sync active-high), btn_in (raw async button),
//        press (accept/repeat pulse), level (debounced state), held (auto-repeat active).
module btn_set_cond
  import btn_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 1000,
  parameter int REPEAT_MS   = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press,
  output logic level,
  output logic held
);

  localparam int DB_CYC   = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int HOLD_CYC = ms_to_cyc(CLK_HZ, HOLD_MS);
  localparam int REP_CYC  = ms_to_cyc(CLK_HZ, REPEAT_MS);
  localparam int CNT_W    = $clog2(max3(DB_CYC, HOLD_CYC, REP_CYC)) + 1;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

  if (DB_CYC < 1 || HOLD_CYC < 1 || REP_CYC < 1) begin : g_bad_params
    $error("btn_set_cond: every derived cycle count must be at least 1");
  end

  logic btn_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  btn_state_t       state;
  logic [CNT_W-1:0] count;

  // One counter serves every timed state; any state change (or repeat pulse)
  // restarts it. In IDLE it free-runs and is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      press <= 1'b0;
      level <= 1'b0;
      held  <= 1'b0;
    end else begin
      press <= 1'b0;
      count <= count + 1'b1;
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= DB_PRESS;
            count <= '0;
          end
        end
        DB_PRESS: begin
          if (!btn_s) begin
            state <= IDLE;
            count <= '0;
          end else if (count == DB_LAST) begin
            state <= PRESSED;
            count <= '0;
            press <= 1'b1;
            level <= 1'b1;
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state <= DB_RELEASE;
            count <= '0;
          end else if (count == HOLD_LAST) begin
            state <= REPEAT;
            count <= '0;
            press <= 1'b1;
            held  <= 1'b1;
          end
        end
        REPEAT: begin
          if (!btn_s) begin
            state <= DB_RELEASE;
            count <= '0;
          end else if (count == REP_LAST) begin
            count <= '0;
            press <= 1'b1;
          end
        end
        DB_RELEASE: begin
          // A bounce back high resumes whichever phase we came from, with a
          // fresh timer and no pulse; held remembers which one that was.
          if (btn_s) begin
            state <= held ? REPEAT : PRESSED;
            count <= '0;
          end else if (count == DB_LAST) begin
            state <= IDLE;
            count <= '0;
            level <= 1'b0;
            held  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_set_cond.sv
module tb_btn_set_cond;

  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic press, level, held;

  always #5 clk = ~clk;

  btn_set_cond #(
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (DB),
    .HOLD_MS     (HOLD),
    .REPEAT_MS   (REP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .press  (press),
    .level  (level),
    .held   (held)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  int base = 0;

  // Behavioural model: debounce as "DB+1 consecutive equal synchronized
  // samples", auto-repeat as elapsed time since the last pulse or since the
  // button came back during a release bounce.
  bit s1 = 0, s2 = 0, m_s = 0;
  int one_run = 0, zero_run = 0, age = 0;
  bit m_press = 0, m_level = 0, m_held = 0;

  always @(posedge clk) begin
    edge_cnt++;
    if (rst) begin
      s1 = 0; s2 = 0;
      one_run = 0; zero_run = 0; age = 0;
      m_press = 0; m_level = 0; m_held = 0;
    end else begin
      m_s = s2;
      s2  = s1;
      s1  = btn_in;
      m_press = 0;
      if (m_s) begin one_run++; zero_run = 0; end
      else     begin zero_run++; one_run = 0; end
      if (!m_level) begin
        if (one_run == DB + 1) begin
          m_level = 1; m_press = 1; age = 0;
        end
      end else if (!m_s) begin
        if (zero_run == DB + 1) begin
          m_level = 0; m_held = 0;
        end
      end else if (one_run == 1) begin
        age = 0;
      end else begin
        age++;
        if (age == (m_held ? REP : HOLD)) begin
          m_press = 1; m_held = 1; age = 0;
        end
      end
    end
  end

  // Compare process plus per-scenario recording of pulse times and levels.
  int press_at[$];
  bit lvl_hist[0:255];
  bit held_hist[0:255];
  int c;

  always @(negedge clk) begin
    n_tests++;
    if ({press, level, held} !== {m_press, m_level, m_held}) begin
      n_fail++;
      $display("FAIL model_cmp edge %0d: dut press/level/held=%b%b%b expected %b%b%b",
               edge_cnt, press, level, held, m_press, m_level, m_held);
    end
    c = edge_cnt - base;
    if (press === 1'b1) press_at.push_back(c);
    if (c >= 0 && c < 256) begin
      lvl_hist[c]  = level;
      held_hist[c] = held;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_to(input int k);
    while (edge_cnt - base < k) step();
  endtask

  task automatic start();
    base = edge_cnt;
    press_at.delete();
    for (int i = 0; i < 256; i++) begin
      lvl_hist[i]  = 0;
      held_hist[i] = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_list(input string name, input int exp[$]);
    chk({name, "_count"}, press_at.size(), exp.size());
    for (int i = 0; i < exp.size() && i < press_at.size(); i++)
      chk($sformatf("%s_pulse%0d", name, i), press_at[i], exp[i]);
  endtask

  int exp_q[$];
  int flag;
  int pat[5];

  initial begin
    // Reset state
    rst = 1; btn_in = 0;
    step(); step();
    chk("rst_press", press, 0);
    chk("rst_level", level, 0);
    chk("rst_held",  held,  0);
    rst = 0;
    step(); step();

    // Clean press held 10 cycles
    start();
    btn_in = 1; run_to(10);
    btn_in = 0; run_to(30);
    exp_q = '{7};
    chk_list("clean", exp_q);
    chk("clean_lvl6",  lvl_hist[6],  0);
    chk("clean_lvl7",  lvl_hist[7],  1);
    chk("clean_lvl16", lvl_hist[16], 1);
    chk("clean_lvl17", lvl_hist[17], 0);
    flag = 0;
    for (int i = 0; i < 30; i++) flag |= held_hist[i];
    chk("clean_never_held", flag, 0);

    // Bounce shorter than the debounce window
    start();
    pat = '{1, 0, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      btn_in = pat[i][0];
      step();
    end
    btn_in = 0; run_to(20);
    chk("bounce_pulses", press_at.size(), 0);
    flag = 0;
    for (int i = 0; i < 20; i++) flag |= lvl_hist[i] | held_hist[i];
    chk("bounce_level_held", flag, 0);

    // Hold 50 cycles: accept then auto-repeat
    start();
    btn_in = 1; run_to(50);
    btn_in = 0; run_to(70);
    exp_q = '{7, 27, 32, 37, 42, 47, 52};
    chk_list("hold", exp_q);
    chk("hold_held26", held_hist[26], 0);
    chk("hold_held27", held_hist[27], 1);
    chk("hold_held56", held_hist[56], 1);
    chk("hold_held57", held_hist[57], 0);
    chk("hold_lvl57",  lvl_hist[57],  0);

    // Two-cycle low glitch while repeating
    start();
    btn_in = 1; run_to(33);
    btn_in = 0; run_to(35);
    btn_in = 1; run_to(50);
    btn_in = 0; run_to(70);
    exp_q = '{7, 27, 32, 43, 48};
    chk_list("glitch", exp_q);
    flag = 1;
    for (int i = 27; i < 57; i++) flag &= held_hist[i] & lvl_hist[i];
    chk("glitch_held_level_stay", flag, 1);

    // One-cycle reset while repeating, button still held
    start();
    btn_in = 1; run_to(30);
    rst = 1; step();
    rst = 0;
    run_to(60);
    btn_in = 0; run_to(80);
    exp_q = '{7, 27, 38, 58};
    chk_list("midrst", exp_q);
    chk("midrst_lvl31",  lvl_hist[31],  0);
    chk("midrst_held31", held_hist[31], 0);
    chk("midrst_lvl38",  lvl_hist[38],  1);

    // Button already pressed while reset is held
    press_at.delete();
    rst = 1; btn_in = 1;
    step(); step(); step(); step();
    chk("prerst_no_pulse", press_at.size(), 0);
    chk("prerst_level", level, 0);
    start();
    rst = 0;
    run_to(15);
    btn_in = 0; run_to(35);
    exp_q = '{7};
    chk_list("prerst", exp_q);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
